rv32i_exec_mem: RTL and testbench

Combined execute/memory stage for the single-cycle RV32I core. It holds the instruction decoder, the 32-bit ALU, branch resolution, and a unified byte-addressed instruction/data memory. The top-level bus drives it with the PC and the register-file read data, and it returns the fetched instruction, register-writeback controls, and the next PC. The register file and the immediate generator are external.

---
 rtl/rv32i_exec_mem_if.sv | 31 +++
 rtl/rv32i_exec_mem.sv | 218 +++++++++++++++++++++
 tb/tb_rv32i_exec_mem.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/rv32i_exec_mem_if.sv
// rtl/rv32i_exec_mem_if.sv - execute/memory stage bus: program load, operands in, fetch/writeback/next-pc out
interface rv32i_exec_mem_if;
    logic        load_we;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [31:0] instr;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [4:0]  rd_idx;
    logic        reg_write;
    logic [31:0] wb_data;
    logic [31:0] next_pc;
    logic [31:0] alu_result;
    logic        alu_zero;

    modport slave (
        input  load_we, load_addr, load_data, pc, rs1_data, rs2_data, imm,
        output instr, rs1_idx, rs2_idx, rd_idx, reg_write, wb_data, next_pc,
               alu_result, alu_zero
    );

    modport master (
        output load_we, load_addr, load_data, pc, rs1_data, rs2_data, imm,
        input  instr, rs1_idx, rs2_idx, rd_idx, reg_write, wb_data, next_pc,
               alu_result, alu_zero
    );
endinterface

// File: rtl/rv32i_exec_mem.sv
// rtl/rv32i_exec_mem.sv - single-cycle RV32I decode, ALU, branch resolution and unified byte memory
module rv32i_exec_mem #(
    parameter int MEM_BYTES = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    rv32i_exec_mem_if.slave     bus
);
    localparam int AW = $clog2(MEM_BYTES);

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10;

    localparam logic [6:0] OPC_OP = 7'h33, OPC_OPIMM = 7'h13, OPC_LUI = 7'h37, OPC_AUIPC = 7'h17,
                           OPC_LOAD = 7'h03, OPC_STORE = 7'h23, OPC_BRANCH = 7'h63,
                           OPC_JAL = 7'h6F, OPC_JALR = 7'h67;

    logic [7:0] r_mem [MEM_BYTES];

    logic [AW-3:0] w_fetch_idx;
    logic [31:0]   w_instr_raw;
    logic [31:0]   w_instr;
    logic [6:0]    w_opcode;
    logic [2:0]    w_funct3;
    logic          w_funct7b5;

    logic          w_reg_write, w_mem_write, w_mem_read, w_mem_to_reg;
    logic          w_branch, w_jump, w_link, w_branch_from_pc, w_reverse;
    logic [1:0]    w_alu_src;
    logic [3:0]    w_alu_op;

    logic [31:0]   w_in1, w_in2, w_alu;
    logic [4:0]    w_shamt;
    logic          w_taken;
    logic [31:0]   w_target, w_pc_plus4;

    logic [AW-1:0] w_daddr;
    logic [31:0]   w_dword;
    logic [7:0]    w_lbyte;
    logic [15:0]   w_lhalf;
    logic [31:0]   w_load_value;
    logic [3:0]    w_store_be;
    logic [31:0]   w_store_data;
    logic          w_unused;

    assign w_fetch_idx = bus.pc[AW-1:2];
    assign w_instr_raw = {r_mem[{w_fetch_idx, 2'b11}], r_mem[{w_fetch_idx, 2'b10}],
                          r_mem[{w_fetch_idx, 2'b01}], r_mem[{w_fetch_idx, 2'b00}]};
    assign w_instr     = rst_n ? w_instr_raw : 32'h0000_0013;
    assign w_opcode    = w_instr[6:0];
    assign w_funct3    = w_instr[14:12];
    assign w_funct7b5  = w_instr[30];

    always_comb begin
        w_reg_write      = 1'b0;
        w_mem_write      = 1'b0;
        w_mem_read       = 1'b0;
        w_mem_to_reg     = 1'b0;
        w_branch         = 1'b0;
        w_jump           = 1'b0;
        w_link           = 1'b0;
        w_branch_from_pc = 1'b0;
        w_reverse        = 1'b0;
        w_alu_src        = 2'b00;
        w_alu_op         = ALU_ADD;
        unique case (w_opcode)
            OPC_OP, OPC_OPIMM: begin
                w_reg_write = 1'b1;
                w_alu_src   = (w_opcode == OPC_OPIMM) ? 2'b01 : 2'b00;
                case (w_funct3)
                    3'd0: w_alu_op = (w_opcode == OPC_OP && w_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'd1: w_alu_op = ALU_SLL;
                    3'd2: w_alu_op = ALU_SLT;
                    3'd3: w_alu_op = ALU_SLTU;
                    3'd4: w_alu_op = ALU_XOR;
                    3'd5: w_alu_op = w_funct7b5 ? ALU_SRA : ALU_SRL;
                    3'd6: w_alu_op = ALU_OR;
                    default: w_alu_op = ALU_AND;
                endcase
            end
            OPC_LUI: begin
                w_reg_write = 1'b1;
                w_alu_src   = 2'b01;
                w_alu_op    = ALU_PASSB;
            end
            OPC_AUIPC: begin
                w_reg_write = 1'b1;
                w_alu_src   = 2'b11;
            end
            OPC_LOAD: begin
                w_reg_write  = 1'b1;
                w_alu_src    = 2'b01;
                w_mem_read   = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            OPC_STORE: begin
                w_alu_src   = 2'b01;
                w_mem_write = 1'b1;
            end
            OPC_BRANCH: begin
                w_branch_from_pc = 1'b1;
                w_branch         = 1'b1;
                case (w_funct3)
                    3'd0: w_alu_op = ALU_SUB;
                    3'd1: begin w_alu_op = ALU_SUB;  w_reverse = 1'b1; end
                    3'd4: begin w_alu_op = ALU_SLT;  w_reverse = 1'b1; end
                    3'd5: w_alu_op = ALU_SLT;
                    3'd6: begin w_alu_op = ALU_SLTU; w_reverse = 1'b1; end
                    3'd7: w_alu_op = ALU_SLTU;
                    default: w_branch = 1'b0;
                endcase
            end
            OPC_JAL: begin
                w_reg_write      = 1'b1;
                w_branch         = 1'b1;
                w_jump           = 1'b1;
                w_link           = 1'b1;
                w_branch_from_pc = 1'b1;
            end
            OPC_JALR: begin
                w_reg_write = 1'b1;
                w_alu_src   = 2'b01;
                w_branch    = 1'b1;
                w_jump      = 1'b1;
                w_link      = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_in1   = w_alu_src[1] ? bus.pc : bus.rs1_data;
    assign w_in2   = w_alu_src[0] ? bus.imm : bus.rs2_data;
    assign w_shamt = w_in2[4:0];

    always_comb begin
        w_alu = 32'd0;
        case (w_alu_op)
            ALU_ADD:   w_alu = w_in1 + w_in2;
            ALU_SUB:   w_alu = w_in1 - w_in2;
            ALU_SLL:   w_alu = w_in1 << w_shamt;
            ALU_SLT:   w_alu = {31'd0, $signed(w_in1) < $signed(w_in2)};
            ALU_SLTU:  w_alu = {31'd0, w_in1 < w_in2};
            ALU_XOR:   w_alu = w_in1 ^ w_in2;
            ALU_SRL:   w_alu = w_in1 >> w_shamt;
            ALU_SRA:   w_alu = $unsigned($signed(w_in1) >>> w_shamt);
            ALU_OR:    w_alu = w_in1 | w_in2;
            ALU_AND:   w_alu = w_in1 & w_in2;
            ALU_PASSB: w_alu = w_in2;
            default:   w_alu = 32'd0;
        endcase
    end

    // Branch compares reuse the ALU: taken when the zero flag disagrees with reverse
    assign w_pc_plus4 = bus.pc + 32'd4;
    assign w_taken    = w_branch & (w_jump | ((w_alu == 32'd0) ^ w_reverse));
    assign w_target   = w_branch_from_pc ? (bus.pc + bus.imm)
                                         : ((bus.rs1_data + bus.imm) & 32'hFFFF_FFFE);

    assign w_daddr = w_alu[AW-1:0];
    assign w_dword = {r_mem[{w_daddr[AW-1:2], 2'b11}], r_mem[{w_daddr[AW-1:2], 2'b10}],
                      r_mem[{w_daddr[AW-1:2], 2'b01}], r_mem[{w_daddr[AW-1:2], 2'b00}]};
    assign w_lbyte = w_dword[8*w_daddr[1:0] +: 8];
    assign w_lhalf = w_daddr[1] ? w_dword[31:16] : w_dword[15:0];

    always_comb begin
        w_load_value = 32'd0;
        case (w_funct3)
            3'd0: w_load_value = {{24{w_lbyte[7]}}, w_lbyte};
            3'd1: w_load_value = {{16{w_lhalf[15]}}, w_lhalf};
            3'd2: w_load_value = w_dword;
            3'd4: w_load_value = {24'd0, w_lbyte};
            3'd5: w_load_value = {16'd0, w_lhalf};
            default: w_load_value = 32'd0;
        endcase
    end

    always_comb begin
        w_store_be   = 4'b0000;
        w_store_data = bus.rs2_data;
        case (w_funct3)
            3'd0: begin
                w_store_be   = 4'b0001 << w_daddr[1:0];
                w_store_data = {4{bus.rs2_data[7:0]}};
            end
            3'd1: begin
                w_store_be   = w_daddr[1] ? 4'b1100 : 4'b0011;
                w_store_data = {2{bus.rs2_data[15:0]}};
            end
            3'd2: w_store_be = 4'b1111;
            default: w_store_be = 4'b0000;
        endcase
    end

    // Program load is only accepted under reset; stores only outside it
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) begin
                if (bus.load_we)
                    r_mem[{bus.load_addr[AW-1:2], 2'(i)}] <= bus.load_data[8*i +: 8];
            end else if (w_mem_write && w_store_be[i]) begin
                r_mem[{w_daddr[AW-1:2], 2'(i)}] <= w_store_data[8*i +: 8];
            end
        end
    end

    assign bus.instr      = w_instr;
    assign bus.rs1_idx    = w_instr[19:15];
    assign bus.rs2_idx    = w_instr[24:20];
    assign bus.rd_idx     = w_instr[11:7];
    assign bus.reg_write  = rst_n & w_reg_write;
    assign bus.alu_result = w_alu;
    assign bus.alu_zero   = (w_alu == 32'd0);
    assign bus.next_pc    = !rst_n ? 32'd0 : (w_taken ? w_target : w_pc_plus4);
    assign bus.wb_data    = w_mem_to_reg ? w_load_value : (w_link ? w_pc_plus4 : w_alu);

    assign w_unused = ^{bus.load_addr[1:0], bus.load_addr[31:AW], w_mem_read};
endmodule

// File: tb/tb_rv32i_exec_mem.sv
// tb/tb_rv32i_exec_mem.sv - scoreboard bench for rv32i_exec_mem with directed vectors
module tb_rv32i_exec_mem;
    logic clk;
    logic rst_n;

    rv32i_exec_mem_if bus();

    rv32i_exec_mem #(.MEM_BYTES(4096)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  mask;
        logic [31:0] instr;
        logic        reg_write;
        logic [31:0] wb_data;
        logic [31:0] next_pc;
        logic [31:0] alu_result;
    } exp_t;

    localparam logic [4:0] M_INS = 5'b00001, M_RW = 5'b00010, M_WB = 5'b00100,
                           M_NPC = 5'b01000, M_ALU = 5'b10000;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.mask[0]) begin
                n_tests++;
                if (bus.instr !== e.instr) begin
                    n_fail++;
                    $display("FAIL %s instr got %h exp %h", e.name, bus.instr, e.instr);
                end
            end
            if (e.mask[1]) begin
                n_tests++;
                if (bus.reg_write !== e.reg_write) begin
                    n_fail++;
                    $display("FAIL %s reg_write got %b exp %b", e.name, bus.reg_write, e.reg_write);
                end
            end
            if (e.mask[2]) begin
                n_tests++;
                if (bus.wb_data !== e.wb_data) begin
                    n_fail++;
                    $display("FAIL %s wb_data got %h exp %h", e.name, bus.wb_data, e.wb_data);
                end
            end
            if (e.mask[3]) begin
                n_tests++;
                if (bus.next_pc !== e.next_pc) begin
                    n_fail++;
                    $display("FAIL %s next_pc got %h exp %h", e.name, bus.next_pc, e.next_pc);
                end
            end
            if (e.mask[4]) begin
                n_tests++;
                if (bus.alu_result !== e.alu_result) begin
                    n_fail++;
                    $display("FAIL %s alu_result got %h exp %h", e.name, bus.alu_result, e.alu_result);
                end
            end
        end
    end

    task automatic apply(input string nm, input logic rst, input logic [31:0] p,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                         input logic [4:0] m, input logic [31:0] e_ins, input logic e_rw,
                         input logic [31:0] e_wb, input logic [31:0] e_npc, input logic [31:0] e_alu);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n        = rst;
        bus.pc       = p;
        bus.rs1_data = r1;
        bus.rs2_data = r2;
        bus.imm      = im;
        e.name = nm; e.mask = m; e.instr = e_ins; e.reg_write = e_rw;
        e.wb_data = e_wb; e.next_pc = e_npc; e.alu_result = e_alu;
        sb.push_back(e);
    endtask

    logic [31:0] prog_addr [17] = '{32'h00, 32'h10, 32'h14, 32'h20, 32'h24, 32'h28, 32'h2C, 32'h30,
                                    32'h40, 32'h44, 32'h48, 32'h4C, 32'h50, 32'h54, 32'h58, 32'h5C,
                                    32'h100};
    logic [31:0] prog_data [17] = '{32'h00500093, 32'h00208063, 32'h0020C063, 32'h0020A023,
                                    32'h00008183, 32'h00009183, 32'h0000D183, 32'h0000A183,
                                    32'h000100E7, 32'h4020D1B3, 32'h0020B1B3, 32'h0000007F,
                                    32'h00208023, 32'h123450B7, 32'h00000097, 32'h000000EF,
                                    32'h00000000};

    initial begin
        rst_n         = 1'b0;
        bus.load_we   = 1'b0;
        bus.load_addr = 32'd0;
        bus.load_data = 32'd0;
        bus.pc        = 32'd0;
        bus.rs1_data  = 32'd0;
        bus.rs2_data  = 32'd0;
        bus.imm       = 32'd0;

        for (int i = 0; i < 17; i++) begin
            @(posedge clk);
            #1;
            bus.load_we   = 1'b1;
            bus.load_addr = prog_addr[i];
            bus.load_data = prog_data[i];
        end
        @(posedge clk);
        #1;
        bus.load_we = 1'b0;

        apply("reset_state", 1'b0, 32'h40, 0, 0, 0, M_INS | M_RW | M_NPC, 32'h13, 1'b0, 0, 32'h0, 0);
        apply("addi", 1'b1, 32'h0, 0, 0, 32'd5, M_INS | M_RW | M_WB | M_NPC,
              32'h00500093, 1'b1, 32'd5, 32'h4, 0);
        apply("beq_taken", 1'b1, 32'h10, 32'd7, 32'd7, 32'h20, M_RW | M_NPC, 0, 1'b0, 0, 32'h30, 0);
        apply("beq_not", 1'b1, 32'h10, 32'd7, 32'd8, 32'h20, M_NPC, 0, 1'b0, 0, 32'h14, 0);
        apply("blt_taken", 1'b1, 32'h14, 32'hFFFF_FFFF, 32'd1, 32'h20, M_NPC, 0, 1'b0, 0, 32'h34, 0);
        apply("blt_not", 1'b1, 32'h14, 32'd1, 32'hFFFF_FFFF, 32'h20, M_NPC, 0, 1'b0, 0, 32'h18, 0);
        apply("jalr", 1'b1, 32'h40, 32'h101, 0, 32'd4, M_RW | M_WB | M_NPC, 0, 1'b1, 32'h44, 32'h104, 0);
        apply("sw", 1'b1, 32'h20, 32'h100, 32'h80402010, 0, M_INS | M_RW | M_NPC | M_ALU,
              32'h0020A023, 1'b0, 0, 32'h24, 32'h100);
        apply("lb", 1'b1, 32'h24, 32'h100, 0, 32'd1, M_RW | M_WB | M_ALU, 0, 1'b1, 32'h20, 0, 32'h101);
        apply("lh", 1'b1, 32'h28, 32'h100, 0, 32'd3, M_WB, 0, 1'b0, 32'hFFFF8040, 0, 0);
        apply("lhu", 1'b1, 32'h2C, 32'h100, 0, 32'd3, M_WB, 0, 1'b0, 32'h00008040, 0, 0);
        apply("lw", 1'b1, 32'h30, 32'h100, 0, 32'd2, M_WB, 0, 1'b0, 32'h80402010, 0, 0);
        apply("sb", 1'b1, 32'h50, 32'h100, 32'h000000AB, 32'd2, M_RW | M_ALU, 0, 1'b0, 0, 0, 32'h102);
        apply("lw_after_sb", 1'b1, 32'h30, 32'h100, 0, 0, M_WB, 0, 1'b0, 32'h80AB2010, 0, 0);
        apply("lw_wrap", 1'b1, 32'h30, 32'h1100, 0, 0, M_WB, 0, 1'b0, 32'h80AB2010, 0, 0);
        apply("sra", 1'b1, 32'h44, 32'h80000000, 32'h24, 0, M_RW | M_WB, 0, 1'b1, 32'hF8000000, 0, 0);
        apply("sltu", 1'b1, 32'h48, 32'd1, 32'hFFFF_FFFF, 0, M_WB, 0, 1'b0, 32'd1, 0, 0);
        apply("lui", 1'b1, 32'h54, 0, 0, 32'h12345000, M_RW | M_WB, 0, 1'b1, 32'h12345000, 0, 0);
        apply("auipc", 1'b1, 32'h58, 0, 0, 32'h1000, M_WB, 0, 1'b0, 32'h1058, 0, 0);
        apply("jal", 1'b1, 32'h5C, 0, 0, 32'h100, M_RW | M_WB | M_NPC, 0, 1'b1, 32'h60, 32'h15C, 0);
        apply("undef_op", 1'b1, 32'h4C, 32'd3, 32'd4, 0, M_RW | M_NPC, 0, 1'b0, 0, 32'h50, 0);
        apply("sw_in_reset", 1'b0, 32'h20, 32'h100, 32'hDEADBEEF, 0, M_INS | M_RW | M_NPC,
              32'h13, 1'b0, 0, 32'h0, 0);
        apply("lw_after_rst", 1'b1, 32'h30, 32'h100, 0, 0, M_WB | M_NPC, 0, 1'b0, 32'h80AB2010, 32'h34, 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d left exp 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
